// File: rtl/rsa_modexp_core.sv
// Right-to-left binary modular exponentiation using bit-serial Montgomery products.
// Optional macro RSA_MODEXP_EARLY_EXIT_EN stops after the most-significant set exponent bit.
module rsa_modexp_core #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_busy,
  output logic             o_finished,
  output logic [2:0]       dbg_state
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] W_C  = CW'(WIDTH);
  localparam logic [CW-1:0] W_M1 = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MONT, S_UPDATE, S_DONE} state_t;

  state_t state, state_nx;
  logic [CW-1:0]    cnt, k, k_inc;
  logic [WIDTH-1:0] n_r, d_r, m_r, t_r, tsh;
  logic [WIDTH+1:0] acc_mt, acc_tt;
  logic [WIDTH:0]   prep_dbl, prep_sub;
  logic [WIDTH-1:0] prep_nx, mt_red, tt_red, m_new, d_sh;
  logic [WIDTH+1:0] mt_sub, tt_sub;
  logic             d_bit, last_bit, zero_exp;

  // One Montgomery iteration: add x_i*y, make even by adding n, halve.
  function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] acc, input logic b,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    s = acc + (b ? {2'b00, y} : '0);
    if (s[0]) s = s + {2'b00, n};
    return s >> 1;
  endfunction

  always_comb begin
    prep_dbl = {t_r, 1'b0};
    prep_sub = prep_dbl - {1'b0, n_r};
    prep_nx  = (prep_dbl >= {1'b0, n_r}) ? prep_sub[WIDTH-1:0] : prep_dbl[WIDTH-1:0];
    mt_sub   = acc_mt - {2'b00, n_r};
    tt_sub   = acc_tt - {2'b00, n_r};
    mt_red   = (acc_mt >= {2'b00, n_r}) ? mt_sub[WIDTH-1:0] : acc_mt[WIDTH-1:0];
    tt_red   = (acc_tt >= {2'b00, n_r}) ? tt_sub[WIDTH-1:0] : acc_tt[WIDTH-1:0];
    k_inc    = k + 1'b1;
    d_sh     = d_r >> k;
    d_bit    = d_sh[0];
    m_new    = d_bit ? mt_red : m_r;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    last_bit = ((d_r >> k_inc) == '0);
    zero_exp = (d_r == '0);
`else
    last_bit = (k_inc == W_C);
    zero_exp = 1'b0;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (i_start) state_nx = S_PREP;
      S_PREP:   if (cnt == W_C) state_nx = zero_exp ? S_DONE : S_MONT;
      S_MONT:   if (cnt == W_M1) state_nx = S_UPDATE;
      S_UPDATE: state_nx = last_bit ? S_DONE : S_MONT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // m stays in the normal domain and t in the Montgomery domain, so m needs no final conversion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0; k <= '0; n_r <= '0; d_r <= '0; m_r <= '0; t_r <= '0; tsh <= '0;
      acc_mt <= '0; acc_tt <= '0; o_a_pow_d <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          n_r <= i_n; d_r <= i_d; t_r <= i_a; m_r <= WIDTH'(1);
          k <= '0; cnt <= '0;
        end
        S_PREP: begin
          if (cnt != W_C) begin
            t_r <= prep_nx;
            cnt <= cnt + 1'b1;
          end else begin
            tsh <= t_r; acc_mt <= '0; acc_tt <= '0; cnt <= '0;
            if (zero_exp) o_a_pow_d <= m_r;
          end
        end
        S_MONT: begin
          acc_mt <= mont_step(acc_mt, tsh[0], m_r, n_r);
          acc_tt <= mont_step(acc_tt, tsh[0], t_r, n_r);
          tsh    <= tsh >> 1;
          cnt    <= (cnt == W_M1) ? '0 : cnt + 1'b1;
        end
        S_UPDATE: begin
          m_r <= m_new; t_r <= tt_red; tsh <= tt_red;
          acc_mt <= '0; acc_tt <= '0; k <= k_inc;
          if (last_bit) o_a_pow_d <= m_new;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (state == S_PREP) || (state == S_MONT) || (state == S_UPDATE);
  assign o_finished = (state == S_DONE);
  assign dbg_state  = state;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: three widths, directed and random vectors against a plain modexp model.
module tb_rsa_modexp_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [63:0] a_in = '0, d_in = '0, n_in = 64'd3;
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [63:0] res64;
  logic [2:0]  busy, fin;
  logic [2:0]  st8, st16, st64;
  logic [63:0] res_v [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_modexp_core #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_a(a_in[7:0]), .i_d(d_in[7:0]),
    .i_n(n_in[7:0]), .o_a_pow_d(res8), .o_busy(busy[0]), .o_finished(fin[0]), .dbg_state(st8));
  rsa_modexp_core #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_a(a_in[15:0]), .i_d(d_in[15:0]),
    .i_n(n_in[15:0]), .o_a_pow_d(res16), .o_busy(busy[1]), .o_finished(fin[1]), .dbg_state(st16));
  rsa_modexp_core #(.WIDTH(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_a(a_in), .i_d(d_in),
    .i_n(n_in), .o_a_pow_d(res64), .o_busy(busy[2]), .o_finished(fin[2]), .dbg_state(st64));

  assign res_v[0] = {56'd0, res8};
  assign res_v[1] = {48'd0, res16};
  assign res_v[2] = res64;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] width_mask(input int w);
    logic [63:0] one = 64'd1;
    return (w == 64) ? '1 : ((one << w) - 64'd1);
  endfunction

  // Square-and-multiply on wide integers.
  function automatic logic [63:0] ref_modexp(input logic [63:0] a, d, n);
    logic [127:0] r, b, nn;
    nn = {64'd0, n};
    r = 128'd1;
    b = {64'd0, a} % nn;
    for (int i = 0; i < 64; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[63:0];
  endfunction

  function automatic int exp_lat(input int w, input logic [63:0] d);
    int kk;
    kk = w;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    kk = 0;
    for (int i = 0; i < w; i++) if (d[i]) kk = i + 1;
`endif
    return w + kk * (w + 1) + 1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_op(input int sel, input int w, input logic [63:0] a, d, n, input int glitch);
    logic [63:0] exp_r;
    int lat, exp_l;
    bit done;
    exp_r = ref_modexp(a, d, n);
    exp_l = exp_lat(w, d);
    @(negedge clk);
    a_in = a; d_in = d; n_in = n; start[sel] = 1'b1;
    @(posedge clk);
    #1 start[sel] = 1'b0;
    a_in = rand64(); d_in = rand64(); n_in = rand64() | 64'd1;
    check("busy_after_start", busy[sel], 1);
    lat = 0; done = 0;
    while (!done && lat < 20000) begin
      if (glitch > 0 && lat == glitch) start[sel] = 1'b1;
      @(posedge clk);
      #1 start[sel] = 1'b0;
      lat++;
      if (fin[sel]) done = 1;
    end
    if (!done) begin
      check("timeout", 0, 1);
      return;
    end
    check("result", res_v[sel], exp_r);
    check("latency", lat, exp_l);
    check("busy_in_done", busy[sel], 0);
    start[sel] = 1'b1;
    @(posedge clk);
    #1 start[sel] = 1'b0;
    check("idle_after_done", {busy[sel], fin[sel]}, 0);
    check("result_hold", res_v[sel], exp_r);
  endtask

  task automatic run_random(input int sel, input int w, input int ops);
    logic [63:0] n, a, d;
    for (int i = 0; i < ops; i++) begin
      n = (rand64() & width_mask(w)) | 64'd1;
      if (n == 64'd1) n = 64'd3;
      a = rand64() % n;
      d = rand64() & width_mask(w);
      if (i == 0) d = 64'd0;
      if (i == 1) d = width_mask(w);
      run_op(sel, w, a, d, n, 0);
    end
  endtask

  initial begin
    int fin_seen;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      check("reset_result", res_v[s], 0);
      check("reset_busy", busy[s], 0);
      check("reset_finished", fin[s], 0);
    end

    run_op(0, 8, 64'd2, 64'd7, 64'd143, 0);
    run_op(0, 8, 64'd142, 64'd2, 64'd143, 0);
    run_op(0, 8, 64'd5, 64'd0, 64'd143, 0);
    run_op(0, 8, 64'd77, 64'd1, 64'd143, 30);
    run_op(2, 64, 64'h1234_5678_9abc_def0, 64'd1, 64'hf123_4567_89ab_cdef, 64 + 20);

    // Abort mid-operation with reset at edge 20.
    @(negedge clk);
    a_in = 64'd2; d_in = 64'd7; n_in = 64'd143; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", res_v[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_finished", fin[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fin_seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (fin[0]) fin_seen++;
    end
    check("no_finish_after_abort", fin_seen, 0);
    do_reset();
    run_op(0, 8, 64'd2, 64'd7, 64'd143, 0);

    run_random(0, 8, 20);
    run_random(1, 16, 40);
    run_random(2, 64, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
